// File: rtl/rob_commit_unit_if.sv
// -----------------------------------------------------------------------------
// rob_commit_unit_if
// ROB dequeue interface between the reorder buffer (writer side, fed by the
// decoder) and the commit unit (reader side).
//
// Signals:
//   rob_empty        ROB holds no entries                     (ROB -> commit)
//   head_ready       head result has been written back        (ROB -> commit)
//   head_opcode[6:0] RV32I major opcode of the head           (ROB -> commit)
//   head_rd[4:0]     destination register of the head         (ROB -> commit)
//   head_value       result value of the head                 (ROB -> commit)
//   head_pc          PC of the head                           (ROB -> commit)
//   head_pred_taken  direction predicted at fetch             (ROB -> commit)
//   head_act_taken   resolved direction                       (ROB -> commit)
//   head_act_target  resolved target                          (ROB -> commit)
//   rob_read         dequeue strobe                           (commit -> ROB)
//
// Modports: master = ROB side, slave = commit unit.
// -----------------------------------------------------------------------------
interface rob_commit_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            rob_empty;
  logic            head_ready;
  logic [6:0]      head_opcode;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_value;
  logic [XLEN-1:0] head_pc;
  logic            head_pred_taken;
  logic            head_act_taken;
  logic [XLEN-1:0] head_act_target;
  logic            rob_read;

  modport master (
    output rob_empty, head_ready, head_opcode, head_rd, head_value, head_pc,
           head_pred_taken, head_act_taken, head_act_target,
    input  rob_read
  );

  modport slave (
    input  rob_empty, head_ready, head_opcode, head_rd, head_value, head_pc,
           head_pred_taken, head_act_taken, head_act_target,
    output rob_read
  );
endinterface

// File: rtl/rob_commit_unit.sv
// -----------------------------------------------------------------------------
// rob_commit_unit
// Retire stage of the out-of-order RV32I core. Drains the ROB head in program
// order, writes results to the architectural regfile, handshakes stores with
// the data-memory port and turns branch/JALR mispredicts into a pipeline flush
// plus a fetch redirect.
//
// Ports:
//   clk               core clock
//   rst               synchronous reset, active low
//   rob               ROB dequeue interface (slave modport, reader side)
//   ld_regfile        regfile write enable (registered, one pulse per retire)
//   commit_rd         regfile write address (registered)
//   commit_value      regfile write data (registered)
//   st_commit_req     store request to data memory (registered)
//   st_commit_ack     store performed
//   flush             pipeline flush, held FLUSH_CYCLES cycles (registered)
//   redirect_valid    one-cycle redirect strobe (registered)
//   redirect_pc       corrected fetch PC (registered)
//   commit_count      retired-instruction counter
//   mispredict_count  mispredict counter
//
// Optional feature macro: COMMIT_PERF_CNT_EN
//   defined   -> commit_count / mispredict_count are live 32-bit wrapping counters
//   undefined -> both outputs read 32'h0 and no counter flops exist
// -----------------------------------------------------------------------------
module rob_commit_unit #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned XLEN         = 32
) (
  input  logic             clk,
  input  logic             rst,
  rob_commit_unit_if.slave rob,
  output logic             ld_regfile,
  output logic [4:0]       commit_rd,
  output logic [XLEN-1:0]  commit_value,
  output logic             st_commit_req,
  input  logic             st_commit_ack,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [31:0]      commit_count,
  output logic [31:0]      mispredict_count
);

  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [3:0]      FLUSH_MAX = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_ST_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } state_e;

  state_e          state_q;
  logic [3:0]      flush_cnt_q;
  logic            ld_regfile_q;
  logic [4:0]      commit_rd_q;
  logic [XLEN-1:0] commit_value_q;
  logic            st_commit_req_q;
  logic            flush_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            commit_ok;
  logic            is_br;
  logic            is_jalr;
  logic            is_store;
  logic            mispredict;
  logic            writes_rd;
  logic            st_ack_fire;
  logic [XLEN-1:0] redirect_target;

  always_comb begin
    is_br     = (rob.head_opcode == OP_BR);
    is_jalr   = (rob.head_opcode == OP_JALR);
    is_store  = (rob.head_opcode == OP_STORE);
    commit_ok = (state_q == S_RUN) && !rob.rob_empty && rob.head_ready;
    // JALR targets are never predicted, so a taken JALR always redirects.
    mispredict = (is_br || is_jalr) &&
                 ((rob.head_pred_taken != rob.head_act_taken) ||
                  (is_jalr && rob.head_act_taken));
    writes_rd  = !is_br && !is_store && (rob.head_rd != 5'd0);
    // A stray ack with no request outstanding is ignored.
    st_ack_fire = (state_q == S_ST_WAIT) && st_commit_req_q && st_commit_ack;
    // Not-taken fall-through wraps naturally at 2^XLEN.
    redirect_target = rob.head_act_taken ? rob.head_act_target
                                         : (rob.head_pc + PC_STEP);
  end

  // Stores dequeue only once memory has acknowledged them.
  assign rob.rob_read = rst && ((commit_ok && !is_store) || st_ack_fire);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= S_RUN;
      flush_cnt_q      <= 4'd0;
      ld_regfile_q     <= 1'b0;
      commit_rd_q      <= 5'd0;
      commit_value_q   <= '0;
      st_commit_req_q  <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      ld_regfile_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (commit_ok) begin
            if (is_store) begin
              state_q         <= S_ST_WAIT;
              st_commit_req_q <= 1'b1;
            end else begin
              if (writes_rd) begin
                ld_regfile_q   <= 1'b1;
                commit_rd_q    <= rob.head_rd;
                commit_value_q <= rob.head_value;
              end
              if (mispredict) begin
                state_q          <= S_FLUSH;
                flush_q          <= 1'b1;
                flush_cnt_q      <= FLUSH_MAX;
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= redirect_target;
              end
            end
          end
        end
        S_ST_WAIT: begin
          if (st_ack_fire) begin
            st_commit_req_q <= 1'b0;
            state_q         <= S_RUN;
          end
        end
        S_FLUSH: begin
          // flush_cnt_q counts the remaining flush cycles after this one.
          if (flush_cnt_q == 4'd0) begin
            flush_q <= 1'b0;
            state_q <= S_RUN;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign ld_regfile     = ld_regfile_q;
  assign commit_rd      = commit_rd_q;
  assign commit_value   = commit_value_q;
  assign st_commit_req  = st_commit_req_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] commit_count_q;
  logic [31:0] commit_count_d;
  logic [31:0] mispredict_count_q;
  logic [31:0] mispredict_count_d;
  logic        flush_entry;

  always_comb begin
    flush_entry        = commit_ok && !is_store && mispredict;
    commit_count_d     = commit_count_q + 32'(rob.rob_read);
    mispredict_count_d = mispredict_count_q + 32'(flush_entry);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      commit_count_q     <= 32'h0;
      mispredict_count_q <= 32'h0;
    end else begin
      commit_count_q     <= commit_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign commit_count     = commit_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  assign commit_count     = 32'h0;
  assign mispredict_count = 32'h0;
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_rob_commit_unit
// Directed bench for rob_commit_unit: a table of single-cycle retire vectors
// plus hand-written sequences for drain, store handshake, reset during a
// store, mispredict/flush and the optional performance counters.
// -----------------------------------------------------------------------------
module tb_rob_commit_unit;

  localparam int FC = 3;

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk;
  logic        rst;
  logic        ld_regfile;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic        st_commit_req;
  logic        st_commit_ack;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] commit_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  rob_commit_unit_if #(.XLEN(32)) rob_if ();

  rob_commit_unit #(.FLUSH_CYCLES(FC), .XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .rob              (rob_if),
    .ld_regfile       (ld_regfile),
    .commit_rd        (commit_rd),
    .commit_value     (commit_value),
    .st_commit_req    (st_commit_req),
    .st_commit_ack    (st_commit_ack),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .commit_count     (commit_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        empty;
    logic        ready;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        pred;
    logic        act;
    logic        exp_read;
    logic        exp_ld;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic e, input logic r, input logic [6:0] op,
                              input logic [4:0] rd, input logic [31:0] v,
                              input logic p, input logic a,
                              input logic xr, input logic xl);
    vec_t t;
    t.empty = e; t.ready = r; t.op = op; t.rd = rd; t.val = v;
    t.pred = p; t.act = a; t.exp_read = xr; t.exp_ld = xl;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic r, input logic [6:0] op,
                       input logic [4:0] rd, input logic [31:0] v, input logic [31:0] pc,
                       input logic p, input logic a, input logic [31:0] tgt);
    rob_if.rob_empty       = e;
    rob_if.head_ready      = r;
    rob_if.head_opcode     = op;
    rob_if.head_rd         = rd;
    rob_if.head_value      = v;
    rob_if.head_pc         = pc;
    rob_if.head_pred_taken = p;
    rob_if.head_act_taken  = a;
    rob_if.head_act_target = tgt;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, OP_REG, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    st_commit_ack = 1'b0;
    idle();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One mispredicting head followed by the full flush window. A ready ALU head
  // is presented during the flush to show it is not dequeued.
  task automatic mispredict(input string nm, input logic [6:0] op, input logic [4:0] rd,
                            input logic [31:0] pc, input logic p, input logic a,
                            input logic [31:0] tgt, input logic [31:0] exp_pc,
                            input logic exp_ld);
    @(negedge clk);
    drive(1'b0, 1'b1, op, rd, 32'h1357_9BDF, pc, p, a, tgt);
    #1 chk({nm, "_rob_read"}, 32'(rob_if.rob_read), 32'd1);
    @(posedge clk); #1;
    chk({nm, "_flush"}, 32'(flush), 32'd1);
    chk({nm, "_redirect_valid"}, 32'(redirect_valid), 32'd1);
    chk({nm, "_redirect_pc"}, redirect_pc, exp_pc);
    chk({nm, "_ld_regfile"}, 32'(ld_regfile), 32'(exp_ld));
    for (int c = 1; c < FC; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, OP_REG, 5'd6, 32'h6666_6666, 32'h0, 1'b0, 1'b0, 32'h0);
      #1 chk({nm, "_flush_rob_read"}, 32'(rob_if.rob_read), 32'd0);
      @(posedge clk); #1;
      chk({nm, "_flush_held"}, 32'(flush), 32'd1);
      chk({nm, "_redirect_once"}, 32'(redirect_valid), 32'd0);
      chk({nm, "_flush_no_ld"}, 32'(ld_regfile), 32'd0);
    end
    @(negedge clk);
    #1 chk({nm, "_flush_last_rob_read"}, 32'(rob_if.rob_read), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_flush_end"}, 32'(flush), 32'd0);
    chk({nm, "_flush_end_ld"}, 32'(ld_regfile), 32'd0);
    @(negedge clk);
    idle();
    $display("txn %s: redirect_pc=%h flush_cycles=%0d", nm, exp_pc, FC);
  endtask

  initial begin
    rst = 1'b0;
    st_commit_ack = 1'b0;
    idle();

    vecs[0] = mk(1'b0, 1'b1, OP_REG,  5'd5,  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[1] = mk(1'b0, 1'b1, OP_REG,  5'd0,  32'h0000_1234, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[2] = mk(1'b1, 1'b1, OP_REG,  5'd3,  32'h3333_3333, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[3] = mk(1'b0, 1'b0, OP_REG,  5'd3,  32'h3333_3333, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[4] = mk(1'b0, 1'b1, OP_LOAD, 5'd9,  32'hCAFE_0001, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[5] = mk(1'b0, 1'b1, OP_JAL,  5'd1,  32'h0000_0064, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[6] = mk(1'b0, 1'b1, OP_BR,   5'd4,  32'h4444_4444, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[7] = mk(1'b0, 1'b1, OP_BR,   5'd4,  32'h4444_4444, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[8] = mk(1'b0, 1'b1, OP_JALR, 5'd2,  32'h0000_0080, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[9] = mk(1'b0, 1'b1, OP_LUI,  5'd31, 32'hFFFF_F000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset state, with a ready head present to show rob_read is held low.
    @(negedge clk);
    drive(1'b0, 1'b1, OP_REG, 5'd5, 32'hAAAA_AAAA, 32'h10, 1'b0, 1'b0, 32'h0);
    #1 chk("rst_rob_read", 32'(rob_if.rob_read), 32'd0);
    @(posedge clk); #1;
    chk("rst_ld_regfile", 32'(ld_regfile), 32'd0);
    chk("rst_commit_rd", 32'(commit_rd), 32'd0);
    chk("rst_commit_value", commit_value, 32'd0);
    chk("rst_st_req", 32'(st_commit_req), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_commit_count", commit_count, 32'd0);
    chk("rst_mispredict_count", mispredict_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();

    // Single-cycle retire table.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].empty, vecs[i].ready, vecs[i].op, vecs[i].rd, vecs[i].val,
            32'h0000_0200, vecs[i].pred, vecs[i].act, 32'h0000_0300);
      #1 chk($sformatf("vec%0d_rob_read", i), 32'(rob_if.rob_read), 32'(vecs[i].exp_read));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ld_regfile", i), 32'(ld_regfile), 32'(vecs[i].exp_ld));
      if (vecs[i].exp_ld) begin
        chk($sformatf("vec%0d_commit_rd", i), 32'(commit_rd), 32'(vecs[i].rd));
        chk($sformatf("vec%0d_commit_value", i), commit_value, vecs[i].val);
      end
      chk($sformatf("vec%0d_flush", i), 32'(flush), 32'd0);
      chk($sformatf("vec%0d_redirect_valid", i), 32'(redirect_valid), 32'd0);
      chk($sformatf("vec%0d_st_req", i), 32'(st_commit_req), 32'd0);
      $display("txn vec%0d: op=%b rd=%0d rob_read=%b ld_regfile=%b",
               i, vecs[i].op, vecs[i].rd, vecs[i].exp_read, ld_regfile);
    end

    // Back-to-back drain of rd=1..4.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, OP_REG, 5'(i), 32'h1111_1111 * i, 32'h0, 1'b0, 1'b0, 32'h0);
      #1 chk($sformatf("drain%0d_rob_read", i), 32'(rob_if.rob_read), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("drain%0d_ld", i), 32'(ld_regfile), 32'd1);
      chk($sformatf("drain%0d_rd", i), 32'(commit_rd), 32'(i));
      chk($sformatf("drain%0d_value", i), commit_value, 32'h1111_1111 * i);
      $display("txn drain%0d: rd=%0d value=%h", i, commit_rd, commit_value);
    end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    chk("drain_end_ld", 32'(ld_regfile), 32'd0);

    // Ack while no store is outstanding is ignored.
    @(negedge clk);
    st_commit_ack = 1'b1;
    #1 chk("stray_ack_rob_read", 32'(rob_if.rob_read), 32'd0);
    @(posedge clk); #1;
    chk("stray_ack_st_req", 32'(st_commit_req), 32'd0);
    @(negedge clk);
    st_commit_ack = 1'b0;

    // Store with ack on the third request cycle.
    drive(1'b0, 1'b1, OP_STORE, 5'd0, 32'h5555_0000, 32'h40, 1'b0, 1'b0, 32'h0);
    #1 chk("st_issue_rob_read", 32'(rob_if.rob_read), 32'd0);
    @(posedge clk); #1;
    chk("st_req_rise", 32'(st_commit_req), 32'd1);
    chk("st_no_ld", 32'(ld_regfile), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      st_commit_ack = (c == 2);
      #1 chk($sformatf("st_wait%0d_rob_read", c), 32'(rob_if.rob_read), 32'(c == 2));
      @(posedge clk); #1;
      chk($sformatf("st_wait%0d_req", c), 32'(st_commit_req), 32'(c != 2));
    end
    @(negedge clk);
    st_commit_ack = 1'b0;
    idle();
    $display("txn store: ack after 3 request cycles, st_commit_req=%b", st_commit_req);

    // Reset in the middle of a store wait drops the request.
    drive(1'b0, 1'b1, OP_STORE, 5'd0, 32'h7777_0000, 32'h44, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("st_rst_req_rise", 32'(st_commit_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    st_commit_ack = 1'b1;
    #1 chk("st_rst_rob_read", 32'(rob_if.rob_read), 32'd0);
    @(posedge clk); #1;
    chk("st_rst_req_drop", 32'(st_commit_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    st_commit_ack = 1'b0;
    drive(1'b0, 1'b1, OP_REG, 5'd8, 32'h8888_8888, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 chk("st_rst_run_rob_read", 32'(rob_if.rob_read), 32'd1);
    @(posedge clk); #1;
    chk("st_rst_run_ld", 32'(ld_regfile), 32'd1);
    chk("st_rst_run_st_req", 32'(st_commit_req), 32'd0);
    @(negedge clk);
    idle();
    $display("txn store_reset: request dropped, back in RUN");

    // Mispredicts.
    mispredict("mp_nt", OP_BR, 5'd0, 32'h0000_0060, 1'b1, 1'b0, 32'h0000_0100,
               32'h0000_0064, 1'b0);
    mispredict("mp_tk", OP_BR, 5'd0, 32'h0000_0060, 1'b0, 1'b1, 32'h0000_0100,
               32'h0000_0100, 1'b0);
    mispredict("mp_wrap", OP_BR, 5'd0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_0100,
               32'h0000_0000, 1'b0);
    mispredict("mp_jalr", OP_JALR, 5'd7, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0200,
               32'h0000_0200, 1'b1);
    chk("mp_jalr_commit_rd", 32'(commit_rd), 32'd7);

    // Performance counters: 8 plain retires plus 2 mispredicts.
    do_reset();
    idle();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, OP_REG, 5'd10, 32'(i), 32'h0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
    end
    @(negedge clk);
    idle();
    mispredict("perf_mp1", OP_BR, 5'd0, 32'h0000_1000, 1'b1, 1'b0, 32'h0,
               32'h0000_1004, 1'b0);
    mispredict("perf_mp2", OP_BR, 5'd0, 32'h0000_2000, 1'b0, 1'b1, 32'h0000_3000,
               32'h0000_3000, 1'b0);
    @(posedge clk); #1;
`ifdef COMMIT_PERF_CNT_EN
    chk("perf_commit_count", commit_count, 32'd10);
    chk("perf_mispredict_count", mispredict_count, 32'd2);
`else
    chk("perf_commit_count", commit_count, 32'd0);
    chk("perf_mispredict_count", mispredict_count, 32'd0);
`endif
    $display("txn perf: commit_count=%0d mispredict_count=%0d", commit_count, mispredict_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Retire stage of the out-of-order RV32I core. Drains the reorder buffer head in program order.
- Writes results to the architectural regfile and handshakes stores to the data-memory port.
- Detects branch/JALR mispredicts at commit and issues a flush plus a PC redirect to fetch, the ROB, the reservation stations and the decoder.
- Acts as the reader on the ROB dequeue interface; the decoder is the writer.

Parameters:
- FLUSH_CYCLES, 1, number of cycles `flush` is held high after a mispredict (1..15).
- XLEN, 32, data/PC width.

Ports:
- clk  in  1  core clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on posedge clk.
- rob_empty  in  1  ROB holds no entries.
- head_ready  in  1  ROB head result has been written back.
- head_opcode  in  7  rv32opcode of the head entry.
- head_rd  in  5  destination register of the head entry.
- head_value  in  XLEN  result value of the head entry.
- head_pc  in  XLEN  PC of the head entry.
- head_pred_taken  in  1  direction predicted at fetch.
- head_act_taken  in  1  resolved direction.
- head_act_target  in  XLEN  resolved target.
- rob_read  out  1  dequeue strobe to the ROB; combinational.
- ld_regfile  out  1  regfile write enable; registered.
- commit_rd  out  5  regfile write address; registered.
- commit_value  out  XLEN  regfile write data; registered.
- st_commit_req  out  1  request to perform the head store; registered.
- st_commit_ack  in  1  store performed.
- flush  out  1  pipeline flush; registered.
- redirect_valid  out  1  one-cycle PC redirect strobe; registered.
- redirect_pc  out  XLEN  corrected fetch PC.
- commit_count  out  32  retired-instruction counter (optional feature).
- mispredict_count  out  32  mispredict counter (optional feature).

Behaviour:
- Reset (rst==0 at posedge):
  - state=RUN.
  - All registered outputs cleared: ld_regfile, commit_rd, commit_value, st_commit_req, flush, redirect_valid, redirect_pc.
  - rob_read=0 while rst==0.
  - Reset overrides every state, including mid-ST_WAIT and mid-FLUSH; a pending store request is dropped.
- Commit condition: state==RUN && !rob_empty && head_ready. At most one retire per cycle.
- RUN, ALU/load/JAL head:
  - rob_read=1 in the same cycle.
  - Next cycle: ld_regfile=1, commit_rd=head_rd, commit_value=head_value, but only if head_rd!=0.
  - If head_rd==0: retire with no write.
- RUN, branch (op_br) or op_jalr head:
  - Mispredict = (head_pred_taken != head_act_taken). op_jalr is treated as mispredict whenever act_taken==1.
  - JALR writes rd exactly like an ALU op. op_br never writes.
  - No mispredict: rob_read=1, retire normally.
  - Mispredict: rob_read=1, then go to FLUSH. Next cycle: flush=1 and redirect_valid=1 (for one cycle), redirect_pc = head_act_taken ? head_act_target : head_pc+4, with wrap modulo 2^XLEN.
- FLUSH:
  - flush held high for exactly FLUSH_CYCLES cycles, then state=RUN.
  - No rob_read while flush==1.
  - The ROB is empty on the first RUN cycle after FLUSH.
- RUN, store head (op_store) meeting the commit condition:
  - rob_read=0; go to ST_WAIT. st_commit_req=1 from the next cycle.
- ST_WAIT:
  - Hold st_commit_req=1 until st_commit_ack==1.
  - In the ack cycle: rob_read=1 (combinational). st_commit_req=0 next cycle, and state=RUN.
  - An ack arriving while st_commit_req==0 is ignored.
- rob_empty==1 or head_ready==0: no action; all strobes 0.
- ld_regfile, redirect_valid and rob_read are single-cycle pulses per retire.
- Back-to-back retires: one per cycle sustained in RUN.

Optional Feature:
- Macro: COMMIT_PERF_CNT_EN.
- Defined:
  - commit_count increments by 1 on every rob_read pulse.
  - mispredict_count increments on every FLUSH entry.
  - Both clear on reset and wrap at 2^32.
- Undefined: both ports are tied to 32'h0 and no counter flops are inferred.

Test Plan:
- ALU commit: head op_reg, rd=5, value=32'hDEAD_BEEF, ready=1 -> rob_read=1 same cycle; next cycle ld_regfile=1, commit_rd=5, commit_value=32'hDEAD_BEEF.
- Drain 4 ready entries rd=1..4 with rob_empty=0 -> 4 consecutive rob_read pulses, 4 consecutive regfile writes in order. An entry with rd=0 produces rob_read but ld_regfile=0.
- Store handshake: head op_store ready, ack delayed 3 cycles -> st_commit_req high 3 cycles, rob_read=1 only in the ack cycle, req low after. rst=0 during the wait -> req=0 next cycle, no rob_read.
- Mispredict: op_br, pc=32'h0000_0060, pred=1, act=0 -> rob_read=1, then flush=1 for FLUSH_CYCLES, redirect_valid=1 once, redirect_pc=32'h0000_0064. Same with pred=0, act=1, target=32'h0000_0100 -> redirect_pc=32'h0000_0100.
- Boundaries: rob_empty=1 with head_ready=1 -> no strobes. head_ready=0 -> stall. Branch at pc=32'hFFFF_FFFC not taken, mispredicted -> redirect_pc=32'h0000_0000.
- With COMMIT_PERF_CNT_EN: 10 retires including 2 mispredicts -> commit_count=10, mispredict_count=2. Without the macro -> both read 0.
